pll_reconfig_seq: RTL
=====================

# pll_reconfig_seq

Sequencer that drives the Avalon-MM management port of the Altera PLL reconfiguration IP attached to the core's two-output PLL (50 MHz reference, video clock plus half-rate clock). On a start request it captures pre-encoded N, M, C0 and C1 counter words. It writes them in a fixed order, triggers the reconfiguration, then waits for the PLL to report stable lock. It sits in the management-clock domain beside the PLL and is driven by the video-mode logic; it reports busy, done and error back to that logic.

## Interface
Parameters:
- LOCK_CYCLES, 1024: consecutive synchronized-locked cycles required before done.
- TIMEOUT, 1048576: maximum cycles from the start write until lock is declared; exceeding it raises error.

Ports:
- clk  in  1  management clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  single-cycle request; sampled only in IDLE.
- n_word  in  18  N counter word: [17] odd, [16] bypass, [15:8] high, [7:0] low.
- m_word  in  18  M counter word, same encoding.
- c0_word  in  18  C0 counter word, same encoding.
- c1_word  in  18  C1 counter word, same encoding.
- pll_locked  in  1  PLL locked output, asynchronous to clk.
- mgmt_address  out  6  Avalon address.
- mgmt_writedata  out  32  Avalon write data.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_waitrequest  in  1  Avalon wait request.
- cfg_busy  out  1  high from the cycle after an accepted start until DONE or ERR.
- cfg_done  out  1  one-cycle pulse on successful lock.
- cfg_err  out  1  sticky timeout flag; cleared on the next accepted start.

## Operation
- pll_locked passes through a 2-flop synchronizer (lock_s) before any use.
- States: IDLE, W_MODE, W_N, W_M, W_C0, W_C1, W_START, WAIT_REL, WAIT_LOCK, DONE, ERR.
- In IDLE, cfg_start=1 captures all four words into internal registers, clears cfg_err, and moves to W_MODE. cfg_start outside IDLE is ignored.
- Write states and their address and data:
  - W_MODE: addr 0x00, data 0x0000_0000 (waitrequest mode).
  - W_N: addr 0x03, data {14'b0, n}.
  - W_M: addr 0x04, data {14'b0, m}.
  - W_C0: addr 0x05, data {9'b0, 5'd0, c0}.
  - W_C1: addr 0x05, data {9'b0, 5'd1, c1}.
  - W_START: addr 0x02, data 0x0000_0001.
- In every write state, mgmt_write=1 and address/data are held stable. The state advances on the first clock edge where mgmt_waitrequest=0.
- WAIT_REL: mgmt_write=0; wait until mgmt_waitrequest=0 and lock_s=0 (PLL has started relocking); then go to WAIT_LOCK.
- WAIT_LOCK: stable counter increments while lock_s=1 and clears to 0 when lock_s=0. Reaching LOCK_CYCLES goes to DONE.
- A timeout counter starts at 0 on the W_START accept edge and increments every cycle in WAIT_REL and WAIT_LOCK. When it reaches TIMEOUT, go to ERR. If timeout and lock completion occur on the same cycle, timeout wins.
- DONE: cfg_done=1 for one cycle, then IDLE.
- ERR: cfg_err is set, then IDLE.
- Counter widths are $clog2 of their limit plus 1; counters saturate and never wrap.

## Timing
- Reset values: state IDLE, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, cfg_busy=0, cfg_done=0, cfg_err=0, both counters 0, synchronizer flops 0.
- Reset asserted mid-write drops mgmt_write immediately (asynchronously). No write resumes after reset.
- With waitrequest held low: start is sampled at edge 0, and mgmt_write is high during cycles 1–6, one write per cycle.
- A stall of k cycles extends the current write by k cycles.
- Minimum start-to-done latency is 6 + 1 + LOCK_CYCLES + 1 cycles, plus a 2-cycle synchronizer delay.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Zero-wait run with n=0x00202, m=0x00A0A, c0=0x00404, c1=0x00808, and lock asserted 20 cycles after start -> write sequence:
  - 0x00:0x0, 0x03:0x202, 0x04:0xA0A,
  - 0x05:0x00404, 0x05:0x40808, 0x02:0x1;
  - cfg_done pulses once; cfg_busy low the cycle after.
- mgmt_waitrequest held high for 3 cycles during W_M -> mgmt_write stays high for 4 cycles with address 0x04 and data stable; the remaining writes are unchanged.
- pll_locked drops for 1 cycle at stable count LOCK_CYCLES-2 -> stable counter clears; cfg_done is delayed by a further full LOCK_CYCLES.
- pll_locked never rises (TIMEOUT=64 in bench) -> cfg_err=1 exactly 64 cycles after the W_START accept edge; cfg_done is never asserted.
  - A following cfg_start clears cfg_err.
- cfg_start pulsed during W_C0 with different words -> ignored; the captured original words are written.
- rst asserted during W_N -> mgmt_write=0 and all outputs at reset values before the next edge.
  - A subsequent start re-runs the full sequence from W_MODE.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - sequences N/M/C0/C1 counter writes into the PLL reconfig IP, then waits for stable lock
module pll_reconfig_seq #(
  parameter int LOCK_CYCLES = 1024,
  parameter int TIMEOUT     = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [17:0] n_word,
  input  logic [17:0] m_word,
  input  logic [17:0] c0_word,
  input  logic [17:0] c1_word,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);
  localparam int SW = $clog2(LOCK_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] S_LIM = SW'(LOCK_CYCLES);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, W_MODE, W_N, W_M, W_C0, W_C1, W_START, WAIT_REL, WAIT_LOCK, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic          lock_m, lock_s;
  logic [17:0]   n_r, m_r, c0_r, c1_r;
  logic [SW-1:0] scnt, scnt_nxt, scnt_inc;
  logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic          capture, write_nxt, busy_nxt;
  logic [5:0]    addr_nxt;
  logic [31:0]   data_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // Both counters saturate at their limit instead of wrapping
  always_comb begin
    scnt_inc = (scnt < S_LIM) ? scnt + 1'b1 : scnt;
    tcnt_inc = (tcnt < T_LIM) ? tcnt + 1'b1 : tcnt;
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = '0;
    tcnt_nxt  = tcnt;
    capture   = 1'b0;
    case (state)
      IDLE: if (cfg_start) begin
        capture   = 1'b1;
        state_nxt = W_MODE;
      end
      W_MODE:  if (!mgmt_waitrequest) state_nxt = W_N;
      W_N:     if (!mgmt_waitrequest) state_nxt = W_M;
      W_M:     if (!mgmt_waitrequest) state_nxt = W_C0;
      W_C0:    if (!mgmt_waitrequest) state_nxt = W_C1;
      W_C1:    if (!mgmt_waitrequest) state_nxt = W_START;
      W_START: if (!mgmt_waitrequest) begin
        state_nxt = WAIT_REL;
        tcnt_nxt  = '0;
      end
      WAIT_REL: begin
        tcnt_nxt = tcnt_inc;
        if (tcnt_inc >= T_LIM)                state_nxt = ERR;
        else if (!mgmt_waitrequest && !lock_s) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        tcnt_nxt = tcnt_inc;
        scnt_nxt = lock_s ? scnt_inc : '0;
        // Timeout is tested first so it wins a tie with lock completion
        if (tcnt_inc >= T_LIM)                 state_nxt = ERR;
        else if (lock_s && scnt_inc >= S_LIM) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered
  always_comb begin
    write_nxt = 1'b0;
    addr_nxt  = 6'h00;
    data_nxt  = 32'h0;
    busy_nxt  = 1'b0;
    case (state_nxt)
      W_MODE:    begin write_nxt = 1'b1; busy_nxt = 1'b1; end
      W_N:       begin write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = 6'h03; data_nxt = {14'b0, n_r}; end
      W_M:       begin write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = 6'h04; data_nxt = {14'b0, m_r}; end
      W_C0:      begin write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = 6'h05; data_nxt = {9'b0, 5'd0, c0_r}; end
      W_C1:      begin write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = 6'h05; data_nxt = {9'b0, 5'd1, c1_r}; end
      W_START:   begin write_nxt = 1'b1; busy_nxt = 1'b1; addr_nxt = 6'h02; data_nxt = 32'h1; end
      WAIT_REL:  busy_nxt = 1'b1;
      WAIT_LOCK: busy_nxt = 1'b1;
      default:   busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      scnt           <= '0;
      tcnt           <= '0;
      n_r            <= '0;
      m_r            <= '0;
      c0_r           <= '0;
      c1_r           <= '0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'h00;
      mgmt_writedata <= 32'h0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      scnt           <= scnt_nxt;
      tcnt           <= tcnt_nxt;
      mgmt_write     <= write_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
      cfg_busy       <= busy_nxt;
      cfg_done       <= (state_nxt == DONE);
      if (capture) begin
        n_r     <= n_word;
        m_r     <= m_word;
        c0_r    <= c0_word;
        c1_r    <= c1_word;
        cfg_err <= 1'b0;
      end else if (state_nxt == ERR) begin
        cfg_err <= 1'b1;
      end
    end
  end
endmodule
